// File: rtl/pcie_tx_arb_if.sv
// Two TLP sources plus the ECP3 core TX port in one bundle.
// The slave modport is the arbiter's view; master is the sources/core side.
interface pcie_tx_arb_if #(
  parameter int DATA_W = 16
);
  logic              s0_req;
  logic              s0_gnt;
  logic              s0_st;
  logic              s0_end;
  logic [DATA_W-1:0] s0_data;
  logic              s1_req;
  logic              s1_gnt;
  logic              s1_st;
  logic              s1_end;
  logic [DATA_W-1:0] s1_data;
  logic              tx_req;
  logic              tx_rdy;
  logic              tx_st;
  logic              tx_end;
  logic [DATA_W-1:0] tx_data;

  modport slave (
    input  s0_req, s0_st, s0_end, s0_data,
    input  s1_req, s1_st, s1_end, s1_data,
    input  tx_rdy,
    output s0_gnt, s1_gnt,
    output tx_req, tx_st, tx_end, tx_data
  );

  modport master (
    output s0_req, s0_st, s0_end, s0_data,
    output s1_req, s1_st, s1_end, s1_data,
    output tx_rdy,
    input  s0_gnt, s1_gnt,
    input  tx_req, tx_st, tx_end, tx_data
  );
endinterface

// File: rtl/pcie_tx_arb.sv
// Two-source packet arbiter for the ECP3 PCIe TX TLP port with beat timeout.
// Define PCIE_TX_ARB_CPL_PRIO_EN to give source 0 strict priority on ties.
module pcie_tx_arb #(
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             pcie_clk,
  input  logic             sys_rst_n,
  pcie_tx_arb_if.slave     bus,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] s0_pkts,
  output logic [CNT_W-1:0] s1_pkts
);

  localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, GAP} state_t;

  state_t             state_q, state_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic               tx_req_q, tx_req_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic [15:0]        beat_q, beat_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   pkts0_q, pkts0_d;
  logic [CNT_W-1:0]   pkts1_q, pkts1_d;

  logic               sel_st, sel_end;
  logic [15:0]        sel_data;
  logic               timeout_hit;
  logic               tx_st_c, tx_end_c;
  logic [15:0]        tx_data_c;

  assign sel_st      = win_q ? bus.s1_st   : bus.s0_st;
  assign sel_end     = win_q ? bus.s1_end  : bus.s0_end;
  assign sel_data    = win_q ? bus.s1_data : bus.s0_data;
  assign timeout_hit = (beat_q == LAST_BEAT) && !sel_end;

  always_ff @(posedge pcie_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      tx_req_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      pkts0_q  <= '0;
      pkts1_q  <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      tx_req_q <= tx_req_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      pkts0_q  <= pkts0_d;
      pkts1_q  <= pkts1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    tx_req_d  = tx_req_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    beat_d    = beat_q;
    err_d     = err_q;
    pkts0_d   = pkts0_q;
    pkts1_d   = pkts1_q;
    tx_st_c   = 1'b0;
    tx_end_c  = 1'b0;
    tx_data_c = '0;

    case (state_q)
      IDLE: begin
        if (bus.s0_req || bus.s1_req) begin
`ifdef PCIE_TX_ARB_CPL_PRIO_EN
          win_d = !bus.s0_req;
`else
          win_d = (bus.s0_req && bus.s1_req) ? !last_q : !bus.s0_req;
`endif
          tx_req_d = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.tx_rdy) begin
          tx_req_d = 1'b0;
          gnt0_d   = !win_q;
          gnt1_d   = win_q;
          last_d   = win_q;
          beat_d   = '0;
          state_d  = XFER;
        end
      end
      XFER: begin
        tx_st_c   = sel_st;
        tx_end_c  = sel_end || timeout_hit;
        tx_data_c = sel_data;
        beat_d    = beat_q + 16'd1;
        // A real end wins over the timeout when both land on the same beat.
        if (sel_end) begin
          if (win_q) pkts1_d = pkts1_q + CNT_W'(1);
          else       pkts0_d = pkts0_q + CNT_W'(1);
          state_d = GAP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.tx_req   = tx_req_q;
  assign bus.s0_gnt   = gnt0_q;
  assign bus.s1_gnt   = gnt1_q;
  assign bus.tx_st    = tx_st_c;
  assign bus.tx_end   = tx_end_c;
  assign bus.tx_data  = tx_data_c;
  assign busy         = (state_q != IDLE);
  assign err_timeout  = err_q;
  assign s0_pkts      = pkts0_q;
  assign s1_pkts      = pkts1_q;

endmodule

// File: doc/pcie_tx_arb.md
Name: pcie_tx_arb

Overview:
- Shares the single 16-bit PCIe TX TLP interface of the ECP3 core (tx_req/tx_rdy/tx_st/tx_end/tx_data) between two TLP sources.
- Source 0 is the completion generator (slave read responses). Source 1 is the master request generator (DMA/NUMA writes and reads).
- Performs the core's request/ready handshake, grants one source per packet, muxes its beats to the core, and guards against hung packets with a beat timeout.

Parameters:
- MAX_BEATS, 1024, maximum 16-bit beats from grant to end before forced termination (1..65535).
- CNT_W, 16, width of the per-source packet counters.

Ports:
- pcie_clk  in  1  PCIe core clock, all logic on rising edge
- sys_rst_n  in  1  synchronous active-low reset
- s0_req  in  1  source 0 wants to send one TLP; held high until s0_gnt
- s0_gnt  out  1  one-cycle grant pulse; source 0 drives s0_st the next cycle
- s0_st  in  1  first beat of source 0 TLP
- s0_end  in  1  last beat of source 0 TLP
- s0_data  in  16  source 0 beat data
- s1_req, s1_gnt, s1_st, s1_end, s1_data  same as above for source 1
- tx_req  out  1  request to core
- tx_rdy  in  1  core ready
- tx_st  out  1  start of TLP to core
- tx_end  out  1  end of TLP to core
- tx_data  out  16  TLP data to core
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; set on forced termination, cleared only by reset
- s0_pkts, s1_pkts  out  CNT_W  packets completed per source; wrap at 2^CNT_W

Behaviour:
- Reset (sys_rst_n=0 at a clock edge) values:
  - tx_req=0, s0_gnt=0, s1_gnt=0, busy=0, err_timeout=0
  - s0_pkts=0, s1_pkts=0, state=IDLE, last=1 (so source 0 wins the first tie)
- Reset asserted mid-packet aborts immediately. No tx_end is generated; the core is expected to be reset together with the arbiter.
- IDLE:
  - If either sN_req=1, latch winner W and go to WAIT with tx_req<=1.
  - Latency: request at edge n gives tx_req high after edge n+1.
  - Arbitration: a single requester wins. If both request, the requester != last wins (round robin).
- WAIT:
  - tx_req stays 1 until tx_rdy=1 is sampled.
  - On that edge: tx_req<=0, sW_gnt<=1 for exactly one cycle, last<=W, beat counter<=0, go to XFER.
- XFER:
  - tx_st/tx_end/tx_data are combinationally driven from sW_st/sW_end/sW_data.
  - The non-winner's inputs are ignored.
  - Beat counter increments every cycle.
  - On sW_end=1: sW_pkts+1, go to GAP.
  - If counter==MAX_BEATS-1 and sW_end=0: force tx_end=1 that cycle, set err_timeout, go to GAP. The packet counter is not incremented.
  - sW_end takes precedence if it coincides with the timeout cycle.
- GAP: one idle cycle (guarantees tx_req does not reassert in the same cycle as tx_end), then IDLE.
- Outside XFER: tx_st=0, tx_end=0, tx_data=16'h0.
- A new request arriving during WAIT/XFER/GAP is held off until IDLE; it is not lost because sources hold req.
- Protocol rule: a source deasserting req before gnt is a source violation. The arbiter still completes the grant, and the timeout recovers.
- Counter arithmetic is modulo 2^CNT_W. The beat counter is 16 bits and saturates is not required (it is bounded by MAX_BEATS).

Optional Feature:
- PCIE_TX_ARB_CPL_PRIO_EN defined: source 0 (completions) has strict priority whenever both request in IDLE. Rationale: avoids completion starvation and deadlock behind posted traffic. The `last` register is still updated but unused.
- Not defined: round robin as described above.

Test Plan:
- Single source: s0_req=1, tx_rdy asserted 3 cycles after tx_req, source sends 6 beats (0x4A00..0x0005) -> tx_req high 3 cycles, one s0_gnt pulse, tx_data sequence identical, tx_st on beat 0, tx_end on beat 5, s0_pkts=1, s1_pkts=0.
- Tie after reset: s0_req=s1_req=1 held for 4 packets -> grant order 0,1,0,1; each source counter reaches 2. With PCIE_TX_ARB_CPL_PRIO_EN, order is 0,0,0,0 while s0_req stays high.
- Timeout: MAX_BEATS=8, granted source never asserts end -> tx_end forced on the 8th XFER cycle, err_timeout=1 and stays 1, counters unchanged, next request is served normally.
- End on timeout cycle: MAX_BEATS=8, s1_end on the 8th beat -> err_timeout stays 0, s1_pkts increments.
- Reset mid-XFER: assert sys_rst_n=0 at beat 3 -> next cycle tx_req=0, tx_st=tx_end=0, busy=0, counters=0, and the next tie is won by source 0.
- Counter wrap: CNT_W=4, 17 packets from source 1 -> s1_pkts=1.
